// File: rtl/dec_scan_pkg.sv
// Shared definitions for the dec_scan_nx decoder/scan sequencer:
// FSM state encoding and mode encoding.
package dec_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dec_scan_nx_if.sv
// Control and output bundle of dec_scan_nx. The optional wrap pulse only
// exists when DEC_WRAP_PULSE_EN is defined.
interface dec_scan_nx_if #(
  parameter int N       = 3,
  parameter int DWELL_W = 4
);

  logic               en;
  logic               mode;
  logic [N-1:0]       sel;
  logic [DWELL_W-1:0] dwell;
  logic [2**N-1:0]    d;
  logic [N-1:0]       idx;
  logic               valid;
`ifdef DEC_WRAP_PULSE_EN
  logic               wrap;
`endif

  modport master (
    output en, mode, sel, dwell,
    input  d, idx, valid
`ifdef DEC_WRAP_PULSE_EN
    , input wrap
`endif
  );

  modport slave (
    input  en, mode, sel, dwell,
    output d, idx, valid
`ifdef DEC_WRAP_PULSE_EN
    , output wrap
`endif
  );

endinterface

// File: rtl/dec_scan_nx_onehot_dec.sv
// Purely combinational binary to one-hot decoder: onehot = 1 << bin.
module onehot_dec #(
  parameter int N = 3
) (
  input  logic [N-1:0]    bin,
  output logic [2**N-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[bin] = 1'b1;
  end

endmodule

// File: rtl/dec_scan_nx.sv
// Registered N-to-2**N one-hot decoder with DIRECT and SCAN modes.
// Optional registered wrap pulse enabled by DEC_WRAP_PULSE_EN.
module dec_scan_nx #(
  parameter int N       = 3,
  parameter int DWELL_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  dec_scan_nx_if.slave bus
);

  import dec_scan_pkg::*;

  localparam logic [N-1:0] IDX_MAX = '1;

  state_e             state, state_nxt;
  logic [N-1:0]       idx, idx_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [2**N-1:0]    d, dec_out;
  logic               valid;
`ifdef DEC_WRAP_PULSE_EN
  logic               wrap, wrap_nxt;
`endif

  // Decoding the next index lets D be a true register that is, by
  // construction, exactly the one-hot image of the registered Idx.
  onehot_dec #(.N(N)) u_dec (
    .bin    (idx_nxt),
    .onehot (dec_out)
  );

  always_comb begin
    state_nxt = ST_IDLE;
    if (bus.en) begin
      state_nxt = (bus.mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    idx_nxt  = idx;
    cnt_nxt  = '0;
`ifdef DEC_WRAP_PULSE_EN
    wrap_nxt = 1'b0;
`endif
    case (state_nxt)
      ST_DIRECT: idx_nxt = bus.sel;
      ST_SCAN: begin
        if (state != ST_SCAN) begin
          idx_nxt = '0;
        end else if (cnt >= bus.dwell) begin
          // >= rather than == so a dwell lowered below the count steps at once
          idx_nxt  = idx + 1'b1;
`ifdef DEC_WRAP_PULSE_EN
          wrap_nxt = (idx == IDX_MAX);
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: idx_nxt = idx;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
      d     <= '0;
      valid <= 1'b0;
`ifdef DEC_WRAP_PULSE_EN
      wrap  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      valid <= (state_nxt != ST_IDLE);
      d     <= (state_nxt != ST_IDLE) ? dec_out : '0;
`ifdef DEC_WRAP_PULSE_EN
      wrap  <= wrap_nxt;
`endif
    end
  end

  assign bus.d     = d;
  assign bus.idx   = idx;
  assign bus.valid = valid;
`ifdef DEC_WRAP_PULSE_EN
  assign bus.wrap  = wrap;
`endif

endmodule

// File: tb/tb_dec_scan_nx.sv
// Directed self-checking bench for dec_scan_nx (N=3, DWELL_W=4); wrap checks
// are active when DEC_WRAP_PULSE_EN is defined.
module tb_dec_scan_nx;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [7:0] exp_d [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  dec_scan_nx_if #(.N(3), .DWELL_W(4)) bus ();

  dec_scan_nx #(.N(3), .DWELL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_live(input string name, input logic [2:0] want_idx);
    total++;
    if (bus.idx !== want_idx) begin
      bad++;
      $display("FAIL %s idx got=%0d want=%0d", name, bus.idx, want_idx);
    end
    total++;
    if (bus.d !== exp_d[want_idx]) begin
      bad++;
      $display("FAIL %s d got=%h want=%h", name, bus.d, exp_d[want_idx]);
    end
    total++;
    if (bus.valid !== 1'b1) begin
      bad++;
      $display("FAIL %s valid got=%b want=1", name, bus.valid);
    end
  endtask

  task automatic check_idle(input string name, input logic [2:0] want_idx);
    total++;
    if (bus.d !== 8'h00) begin
      bad++;
      $display("FAIL %s d got=%h want=00", name, bus.d);
    end
    total++;
    if (bus.valid !== 1'b0) begin
      bad++;
      $display("FAIL %s valid got=%b want=0", name, bus.valid);
    end
    total++;
    if (bus.idx !== want_idx) begin
      bad++;
      $display("FAIL %s idx got=%0d want=%0d", name, bus.idx, want_idx);
    end
  endtask

  task automatic check_wrap(input string name, input logic want);
`ifdef DEC_WRAP_PULSE_EN
    total++;
    if (bus.wrap !== want) begin
      bad++;
      $display("FAIL %s wrap got=%b want=%b", name, bus.wrap, want);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.en    = 1'b1;
    bus.mode  = 1'b1;
    bus.sel   = 3'd5;
    bus.dwell = 4'd0;
    step();
    step();
    check_idle("reset", 3'd0);
    check_wrap("reset", 1'b0);
  endtask

  task automatic test_direct();
    rst_n    = 1'b1;
    bus.en   = 1'b1;
    bus.mode = 1'b0;
    for (int s = 0; s < 8; s++) begin
      bus.sel = 3'(s);
      step();
      check_live($sformatf("direct_sel%0d", s), 3'(s));
    end
  endtask

  task automatic test_scan_dwell2();
    bus.mode  = 1'b1;
    bus.dwell = 4'd2;
    bus.sel   = 3'd6;
    step();
    check_live("scan2_entry", 3'd0);
    check_wrap("scan2_entry", 1'b0);
    for (int k = 1; k <= 24; k++) begin
      step();
      check_live($sformatf("scan2_k%0d", k), 3'((k / 3) % 8));
      check_wrap($sformatf("scan2_k%0d", k), k == 24);
    end
  endtask

  task automatic test_scan_dwell0();
    bus.en = 1'b0;
    step();
    check_idle("idle_between", 3'd0);
    bus.en    = 1'b1;
    bus.mode  = 1'b1;
    bus.dwell = 4'd0;
    step();
    check_live("scan0_entry", 3'd0);
    check_wrap("scan0_entry", 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check_live($sformatf("scan0_k%0d", k), 3'(k % 8));
      check_wrap($sformatf("scan0_k%0d", k), k == 8);
    end
  endtask

  task automatic test_dwell_live();
    bus.en = 1'b0;
    step();
    bus.en    = 1'b1;
    bus.dwell = 4'd7;
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      check_live($sformatf("dwell7_k%0d", k), 3'd0);
    end
    bus.dwell = 4'd2;
    step();
    check_live("dwell_lowered", 3'd1);
  endtask

  task automatic test_mid_op();
    bus.en = 1'b0;
    step();
    bus.en    = 1'b1;
    bus.mode  = 1'b1;
    bus.dwell = 4'd0;
    step();
    for (int k = 1; k <= 5; k++) step();
    check_live("mid_at5", 3'd5);
    bus.mode = 1'b0;
    bus.sel  = 3'd3;
    step();
    check_live("mid_to_direct", 3'd3);
    bus.mode = 1'b1;
    step();
    check_live("mid_rescan", 3'd0);
    check_wrap("mid_rescan", 1'b0);
    step();
    check_live("mid_rescan_step", 3'd1);
    bus.en = 1'b0;
    step();
    check_idle("mid_en_drop", 3'd1);
    bus.en = 1'b1;
    step();
    check_live("mid_reenable", 3'd0);
  endtask

  task automatic test_reset_mid();
    bus.mode  = 1'b1;
    bus.dwell = 4'd0;
    for (int k = 1; k <= 4; k++) step();
    check_live("rstmid_at4", 3'd4);
    rst_n = 1'b0;
    step();
    check_idle("rstmid_reset", 3'd0);
    check_wrap("rstmid_reset", 1'b0);
    rst_n = 1'b1;
    step();
    check_live("rstmid_entry", 3'd0);
    step();
    check_live("rstmid_step", 3'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_direct();
    test_scan_dwell2();
    test_scan_dwell0();
    test_dwell_live();
    test_mid_op();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
